// File: rtl/serial_adder.sv
// Digit-serial adder: one DIGIT-wide slice and a registered carry compute a + b + cin
// over WIDTH/DIGIT cycles, LSB digit first, with valid/ready handshakes on both sides.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_adder: DIGIT must be >= 1 and divide WIDTH exactly");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  function automatic logic [DIGIT:0] f_slice_add(input logic [DIGIT-1:0] x,
                                                 input logic [DIGIT-1:0] y,
                                                 input logic             c);
    return {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, c};
  endfunction

  // a_msb ^ b_msb ^ sum_msb recovers the carry into the MSB
  function automatic logic f_ovf(input logic a_msb, input logic b_msb,
                                 input logic s_msb, input logic c_out);
    return a_msb ^ b_msb ^ s_msb ^ c_out;
  endfunction

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_acc;
  logic               r_carry;
  logic [CW-1:0]      r_k;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_ovf;

  logic [DIGIT:0]         w_slice;
  logic [WIDTH+DIGIT-1:0] w_acc_cat;
  logic [WIDTH+DIGIT-1:0] w_a_cat;
  logic [WIDTH+DIGIT-1:0] w_b_cat;
  logic [WIDTH-1:0]       w_acc_next;
  logic [WIDTH-1:0]       w_a_next;
  logic [WIDTH-1:0]       w_b_next;
  logic                   w_last;

  // Operands shift right one digit per cycle so the slice always reads the low digit;
  // result digits enter the accumulator from the top.
  assign w_slice    = f_slice_add(r_a[DIGIT-1:0], r_b[DIGIT-1:0], r_carry);
  assign w_acc_cat  = {w_slice[DIGIT-1:0], r_acc};
  assign w_a_cat    = {{DIGIT{1'b0}}, r_a};
  assign w_b_cat    = {{DIGIT{1'b0}}, r_b};
  assign w_acc_next = w_acc_cat[WIDTH+DIGIT-1:DIGIT];
  assign w_a_next   = w_a_cat[WIDTH+DIGIT-1:DIGIT];
  assign w_b_next   = w_b_cat[WIDTH+DIGIT-1:DIGIT];
  assign w_last     = (r_k == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_carry     <= 1'b0;
      r_k         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= b;
            r_carry    <= cin;
            r_k        <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_CALC;
          end
        end
        S_CALC: begin
          r_a     <= w_a_next;
          r_b     <= w_b_next;
          r_acc   <= w_acc_next;
          r_carry <= w_slice[DIGIT];
          r_k     <= r_k + CW'(1);
          if (w_last) begin
            r_sum       <= w_acc_next;
            r_cout      <= w_slice[DIGIT];
            r_ovf       <= f_ovf(r_a[DIGIT-1], r_b[DIGIT-1], w_slice[DIGIT-1], w_slice[DIGIT]);
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: table vectors, backpressure and reset-abort sequences on an
// 8/1 instance, plus scoreboarded runs on 8/4, 8/8 and an exhaustive 3/1 instance.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         acc;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       c;
    logic       o;
  } vec_t;

  // ---------------- main instance: WIDTH=8, DIGIT=1 ----------------
  logic       rst_n, in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
  logic [7:0] a, b, sum;

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  exp_t q[$];
  exp_t me;
  logic prev_ov = 1'b0;
  logic chk_rdy = 1'b0;

  always @(negedge clk) begin
    if (chk_rdy) begin
      check("ready_after_handshake", 32'(in_ready), 32'd1);
      check("valid_after_handshake", 32'(out_valid), 32'd0);
    end
    chk_rdy <= 1'b0;
    if (rst_n && out_valid && !prev_ov) begin
      if (q.size() == 0) check("spurious_out_valid", 32'(out_valid), 32'd0);
      else               check("latency", 32'(cyc - q[0].acc), 32'd8);
    end
    if (rst_n && out_valid && out_ready && q.size() > 0) begin
      me = q.pop_front();
      check("sum",  32'(sum),  32'(me.sum));
      check("cout", 32'(cout), 32'(me.cout));
      check("ovf",  32'(ovf),  32'(me.ovf));
      chk_rdy <= 1'b1;
    end
    prev_ov <= out_valid;
  end

  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                       input logic [7:0] es, input logic ec, input logic eo);
    exp_t e;
    bit   ok = 0;
    @(posedge clk); #1;
    a = ia; b = ib; cin = ic; in_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        e.sum = es; e.cout = ec; e.ovf = eo; e.acc = cyc;
        q.push_back(e);
        ok = 1;
      end
    end
    in_valid = 1'b0;
    a = ~ia; b = ~ib; cin = ~ic;
    if (!ok) check("accept_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (q.size() == 0 && in_ready) break;
    end
    if (i == 200) begin
      check("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  // ---------------- extra configurations ----------------
  localparam int CFG_W[3] = '{8, 8, 3};
  localparam int CFG_D[3] = '{4, 8, 1};

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int W = CFG_W[g];
    localparam int D = CFG_D[g];
    localparam int N = W / D;

    logic         rn, iv, ir, ci, ov, orr, co, of;
    logic [W-1:0] ga, gb, gs;
    logic         done = 1'b0;
    logic         gprev = 1'b0;
    exp_t         gq[$];
    exp_t         ge;

    serial_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk(clk), .rst_n(rn), .in_valid(iv), .in_ready(ir),
      .a(ga), .b(gb), .cin(ci), .out_valid(ov), .out_ready(orr),
      .sum(gs), .cout(co), .ovf(of)
    );

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      exp_t     r;
      logic [W:0] t;
      int       s;
      t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
      s = int'($signed(x)) + int'($signed(y)) + int'(c);
      r.sum  = 8'(t[W-1:0]);
      r.cout = t[W];
      r.ovf  = (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
      r.acc  = 0;
      return r;
    endfunction

    initial begin
      orr = 1'b1;
      forever begin
        @(posedge clk); #1;
        orr = ($urandom_range(0, 3) != 0);
      end
    end

    always @(negedge clk) begin
      if (rn && ov && !gprev) begin
        if (gq.size() == 0) check($sformatf("cfg%0d_spurious_valid", g), 32'(ov), 32'd0);
        else                check($sformatf("cfg%0d_latency", g), 32'(cyc - gq[0].acc), 32'(N));
      end
      if (rn && ov && orr && gq.size() > 0) begin
        ge = gq.pop_front();
        check($sformatf("cfg%0d_sum", g),  32'(gs), 32'(ge.sum));
        check($sformatf("cfg%0d_cout", g), 32'(co), 32'(ge.cout));
        check($sformatf("cfg%0d_ovf", g),  32'(of), 32'(ge.ovf));
      end
      gprev <= ov;
    end

    initial begin
      int       cnt;
      logic [W-1:0] xa, xb;
      logic     xc;
      exp_t     e;
      bit       ok;
      rn = 1'b0; iv = 1'b0; ga = '0; gb = '0; ci = 1'b0;
      repeat (2) @(posedge clk);
      #1 rn = 1'b1;
      cnt = (W == 3) ? 128 : 7;
      for (int v = 0; v < cnt; v++) begin
        if (W == 3) begin
          xa = W'(v & 7); xb = W'((v >> 3) & 7); xc = 1'((v >> 6) & 1);
        end else if (v == 0) begin
          xa = W'(8'h7F); xb = W'(8'h01); xc = 1'b0;
        end else begin
          xa = W'($urandom); xb = W'($urandom); xc = 1'($urandom);
        end
        @(posedge clk); #1;
        ga = xa; gb = xb; ci = xc; iv = 1'b1;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
          @(negedge clk);
          if (ir) begin
            @(posedge clk); #1;
            e = model(xa, xb, xc);
            e.acc = cyc;
            gq.push_back(e);
            ok = 1;
          end
        end
        iv = 1'b0;
        ga = ~xa; gb = ~xb;
        if (!ok) check($sformatf("cfg%0d_accept_timeout", g), 32'(ir), 32'd1);
      end
      for (int i = 0; i < 200 && gq.size() != 0; i++) @(negedge clk);
      if (gq.size() != 0) begin
        check($sformatf("cfg%0d_drain_timeout", g), 32'(gq.size()), 32'd0);
        gq.delete();
      end
      done = 1'b1;
    end
  end

  // ---------------- main stimulus ----------------
  vec_t tbl[9];

  initial begin
    bit seen;
    tbl[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[4] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
    tbl[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[6] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    tbl[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[8] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum",       32'(sum),       32'd0);
    check("rst_cout",      32'(cout),      32'd0);
    check("rst_ovf",       32'(ovf),       32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      issue(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].s, tbl[i].c, tbl[i].o);
      drain();
    end
    check("hold_idle_sum", 32'(sum), 32'h0FF);

    // backpressure with a competing operand offered throughout DONE
    @(posedge clk); #1 out_ready = 1'b0;
    issue(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    if (!seen) check("bp_wait_timeout", 32'(out_valid), 32'd1);
    in_valid = 1'b1; a = 8'h01; b = 8'h02; cin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_sum",       32'(sum),       32'h46);
      check("bp_cout",      32'(cout),      32'd0);
      check("bp_in_ready",  32'(in_ready),  32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    me.sum = 8'h03; me.cout = 1'b0; me.ovf = 1'b0; me.acc = cyc;
    q.push_back(me);
    in_valid = 1'b0; a = 8'hEE; b = 8'hDD;
    drain();

    // reset while digit 4 is being processed
    issue(8'h55, 8'h0F, 1'b0, 8'h64, 1'b0, 1'b0);
    @(negedge clk);
    check("hold_calc_sum", 32'(sum), 32'h03);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    q.delete();
    @(negedge clk);
    check("abort_in_ready",  32'(in_ready),  32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_sum",       32'(sum),       32'd0);
    check("abort_cout",      32'(cout),      32'd0);
    repeat (12) @(negedge clk);
    issue(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
    drain();

    for (int i = 0; i < 20000; i++) begin
      if (g_cfg[0].done && g_cfg[1].done && g_cfg[2].done) break;
      @(negedge clk);
    end
    check("cfg_runs_done", 32'(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Parametrised multi-cycle adder. Computes a + b + cin over WIDTH bits, DIGIT bits per clock, LSB digit first, using one DIGIT-wide adder slice and a registered carry. Valid/ready handshakes on both input and output. Also reports carry-out and two's-complement overflow. Used as the area-lean replacement for a flat ripple adder wherever throughput is not critical.

Parameters:
WIDTH, 8, operand and sum width in bits; must be >= 1.
DIGIT, 1, bits processed per cycle; must divide WIDTH exactly. Otherwise elaboration fails.

Ports:
clk        input   1      clock; all logic on rising edge
rst_n      input   1      synchronous active-low reset
in_valid   input   1      operands a, b, cin are valid
in_ready   output  1      block can accept operands
a          input   WIDTH  operand A
b          input   WIDTH  operand B
cin        input   1      carry-in
out_valid  output  1      sum, cout and ovf are valid
out_ready  input   1      consumer accepts the result
sum        output  WIDTH  (a + b + cin) mod 2^WIDTH
cout       output  1      carry out of bit WIDTH-1
ovf        output  1      signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-low (rst_n), sampled on the rising edge of clk.
- Define N = WIDTH/DIGIT.
- Reset (rst_n=0 at an edge):
  - State goes to IDLE.
  - Outputs: in_ready=1, out_valid=0, sum=0, cout=0, ovf=0.
  - The digit counter, carry register and operand registers clear.
  - Reset overrides every other event.
  - Reset mid-CALC or mid-DONE abandons the operation; no out_valid is ever produced for it.
- States:
  - IDLE: in_ready=1, out_valid=0. On an edge with in_valid=1, capture a, b, cin; set digit index to 0; go to CALC. If in_valid=0, stay in IDLE.
  - CALC: in_ready=0, out_valid=0. Each edge adds digit k of a and b (bits k*DIGIT .. k*DIGIT+DIGIT-1) plus the carry register. Store the DIGIT result bits, update the carry register, increment k. On the edge processing digit N-1, load sum/cout/ovf from the internal result and go to DONE. Inputs are ignored in this state.
  - DONE: out_valid=1, in_ready=0. Hold sum, cout and ovf stable. On an edge with out_ready=1, go to IDLE. Otherwise stay in DONE indefinitely.
- Latency:
  - out_valid rises exactly N cycles after the accepting edge.
  - out_valid drops on the edge after the out_ready handshake.
  - Minimum issue interval is N+2 cycles; there is no overlap between transactions.
- Result values:
  - sum, cout and ovf change only on the CALC->DONE edge or on reset.
  - They hold their last value while in IDLE and CALC.
- Carry: the carry register is initialised to the captured cin. It propagates between digits within an operation, never between operations.
- ovf: carry into bit WIDTH-1 XOR cout. When WIDTH=1, ovf = cin XOR cout.
- DIGIT=WIDTH: N=1, so one CALC cycle.
- in_valid and out_ready asserted in DONE together: only the DONE->IDLE transition occurs. The new operand is accepted in IDLE on a later edge.
- Operand inputs may change freely after the accepting edge.

Test Plan:
1. WIDTH=8, DIGIT=1, a=8'h5A, b=8'h33, cin=0, out_ready=1 -> out_valid rises exactly 8 cycles after accept; sum=8'h8D, cout=0, ovf=1; in_ready back to 1 one cycle after the handshake.
2. WIDTH=8, DIGIT=1: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1, ovf=0. Then a=8'h80, b=8'h80, cin=0 -> sum=8'h00, cout=1, ovf=1.
3. Backpressure: hold out_ready=0 for 5 cycles after out_valid with in_valid=1 throughout -> out_valid, sum and cout stay constant; in_ready=0; no second capture. out_ready=1 -> IDLE, then the next operand is accepted.
4. Reset mid-operation: pulse rst_n=0 for one edge at CALC digit 4 -> next cycle in_ready=1, out_valid=0, sum=0, cout=0. out_valid never asserts for the aborted operation. The next operation a=8'h10, b=8'h20 gives sum=8'h30.
5. WIDTH=8, DIGIT=4: a=8'h7F, b=8'h01, cin=0 -> out_valid 2 cycles after accept; sum=8'h80, cout=0, ovf=1. WIDTH=8, DIGIT=8: same operands -> latency 1, same result.
6. WIDTH=3, DIGIT=1: exhaustive loop over all 128 combinations of {a,b,cin}, including all-ones -> {cout,sum} equals a+b+cin and ovf matches the signed-overflow model for every case; latency is always 3.
